// File: rtl/updown_count_ctrl.sv
// Control stage around the 3-bit ripple-carry adder of the up/down counter:
// owns the count register, feeds the adder, and turns its sum/carry into the
// next count with load, enable, modulus wrap, saturate-hold and terminal count.
module updown_count_ctrl #(
    parameter int unsigned MOD         = 8,
    parameter bit          SAT_DEFAULT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up_dn,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       sat_wr,
    input  logic       sat_in,
    input  logic [2:0] add_s,
    input  logic       add_co,
    output logic [2:0] add_a,
    output logic [2:0] add_b,
    output logic [2:0] count,
    output logic       tc,
    output logic       at_limit,
    output logic       dir
);

    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] MAX = CW'(MOD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count_nxt;
    logic            tc_nxt;
    logic            dir_nxt;
    logic            at_limit_nxt;
    logic            sat_q, sat_nxt;
    logic            at_top;
    logic            at_bot;

    // Adder operands: count plus +1 or two's-complement -1.
    assign add_a = count;
    assign add_b = up_dn ? 3'b001 : 3'b111;

    // Top of range: a full 3-bit modulus overflows the adder, so carry-out flags it.
    assign at_top = (MOD == 8) ? add_co : (count == MAX);
    assign at_bot = (count == '0);

    // Next-state, next-count and flag decode; rst is handled in the register.
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        tc_nxt       = 1'b0;
        dir_nxt      = dir;
        sat_nxt      = sat_wr ? sat_in : sat_q;
        if (load) begin
            count_nxt = (load_val > MAX) ? MAX : load_val;
            state_nxt = IDLE;
        end else if (en) begin
            dir_nxt = up_dn;
            if (up_dn ? at_top : at_bot) begin
                tc_nxt = 1'b1;
                if (sat_q) begin
                    state_nxt = HOLD;
                end else begin
                    count_nxt = up_dn ? '0 : MAX;
                    state_nxt = up_dn ? UP : DOWN;
                end
            end else begin
                count_nxt = add_s;
                state_nxt = up_dn ? UP : DOWN;
            end
        end
        at_limit_nxt = (state_nxt == HOLD);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            tc       <= 1'b0;
            at_limit <= 1'b0;
            dir      <= 1'b1;
            sat_q    <= SAT_DEFAULT;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            tc       <= tc_nxt;
            at_limit <= at_limit_nxt;
            dir      <= dir_nxt;
            sat_q    <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Bench for updown_count_ctrl: a MOD=8 instance driven from a vector table
// and a MOD=5 instance driven by a short hand-written sequence. Each DUT gets
// a behavioural 3-bit adder closing the loop from add_a/add_b to add_s/add_co.
module tb_updown_count_ctrl;

    typedef struct {
        logic       rst;
        logic       load;
        logic [2:0] lv;
        logic       en;
        logic       up;
        logic       sat_wr;
        logic       sat_in;
        logic [2:0] e_count;
        logic       e_tc;
        logic       e_lim;
        logic       e_dir;
    } vec_t;

    typedef struct {
        logic [2:0] count;
        logic       tc;
        logic       lim;
        logic       dir;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    exp_t sb[$];

    // Instance with modulus 8
    logic       rst8, en8, up8, load8, sw8, si8;
    logic [2:0] lv8, s8, a8, b8, cnt8;
    logic       co8, tc8, lim8, dir8;
    assign {co8, s8} = 4'(a8) + 4'(b8);

    updown_count_ctrl #(.MOD(8), .SAT_DEFAULT(1'b0)) dut (
        .clk(clk), .rst(rst8), .en(en8), .up_dn(up8), .load(load8), .load_val(lv8),
        .sat_wr(sw8), .sat_in(si8), .add_s(s8), .add_co(co8), .add_a(a8), .add_b(b8),
        .count(cnt8), .tc(tc8), .at_limit(lim8), .dir(dir8)
    );

    // Instance with modulus 5
    logic       rst5, en5, up5, load5, sw5, si5;
    logic [2:0] lv5, s5, a5, b5, cnt5;
    logic       co5, tc5, lim5, dir5;
    assign {co5, s5} = 4'(a5) + 4'(b5);

    updown_count_ctrl #(.MOD(5), .SAT_DEFAULT(1'b0)) dut5 (
        .clk(clk), .rst(rst5), .en(en5), .up_dn(up5), .load(load5), .load_val(lv5),
        .sat_wr(sw5), .sat_in(si5), .add_s(s5), .add_co(co5), .add_a(a5), .add_b(b5),
        .count(cnt5), .tc(tc5), .at_limit(lim5), .dir(dir5)
    );

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic load, input logic [2:0] lv,
                                input logic en, input logic up, input logic sw, input logic si,
                                input logic [2:0] ec, input logic et, input logic el,
                                input logic ed);
        vec_t v;
        v.rst = rst; v.load = load; v.lv = lv; v.en = en; v.up = up;
        v.sat_wr = sw; v.sat_in = si;
        v.e_count = ec; v.e_tc = et; v.e_lim = el; v.e_dir = ed;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one vector into the MOD=8 instance and score the result after the edge.
    task automatic apply8(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst8 = v.rst; load8 = v.load; lv8 = v.lv; en8 = v.en; up8 = v.up;
        sw8 = v.sat_wr; si8 = v.sat_in;
        e.count = v.e_count; e.tc = v.e_tc; e.lim = v.e_lim; e.dir = v.e_dir;
        sb.push_back(e);
        #1;
        chk($sformatf("v%0d add_b", idx), int'(b8), v.up ? 1 : 7);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk($sformatf("v%0d count", idx), int'(cnt8), int'(got.count));
        chk($sformatf("v%0d add_a", idx), int'(a8), int'(got.count));
        chk($sformatf("v%0d tc", idx), int'(tc8), int'(got.tc));
        chk($sformatf("v%0d at_limit", idx), int'(lim8), int'(got.lim));
        chk($sformatf("v%0d dir", idx), int'(dir8), int'(got.dir));
    endtask

    task automatic step5(input logic rst, input logic load, input logic [2:0] lv,
                         input logic en, input logic up, input string name,
                         input logic [2:0] ec, input logic et);
        @(negedge clk);
        rst5 = rst; load5 = load; lv5 = lv; en5 = en; up5 = up; sw5 = 1'b0; si5 = 1'b0;
        @(posedge clk);
        #1;
        chk({name, " count"}, int'(cnt5), int'(ec));
        chk({name, " tc"}, int'(tc5), int'(et));
    endtask

    initial begin
        rst8 = 1'b1; load8 = 1'b0; lv8 = '0; en8 = 1'b0; up8 = 1'b1; sw8 = 1'b0; si8 = 1'b0;
        rst5 = 1'b1; load5 = 1'b0; lv5 = '0; en5 = 1'b0; up5 = 1'b1; sw5 = 1'b0; si5 = 1'b0;

        //              rst load lv en up sw si   cnt tc lim dir
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0,    0, 0, 0, 1));
        for (int i = 1; i <= 9; i++)
            tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 3'(i % 8), (i == 8), 0, 1));
        tbl.push_back(mk(0, 1, 2, 0, 1, 0, 0,    2, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,    1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,    0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,    7, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,    6, 0, 0, 0));
        // saturate at top, hold, leave by a down step
        tbl.push_back(mk(0, 1, 6, 0, 1, 1, 1,    6, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0,    7, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0,    7, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0,    7, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,    6, 0, 0, 0));
        // re-enter HOLD, switch to wrap mode, next same-direction step wraps
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0,    7, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0,    7, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,    7, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0,    0, 1, 0, 1));
        // saturate at bottom, then leave HOLD via load
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1,    0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,    0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,    0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 4, 0, 0, 0, 0,    4, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0,    5, 0, 0, 1));
        // load beats en; rst beats load and en
        tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0,    3, 0, 0, 1));
        tbl.push_back(mk(1, 1, 5, 1, 0, 0, 0,    0, 0, 0, 1));
        // en toggling with up_dn flipped on idle cycles
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0,    1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,    0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,    0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,    7, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,    6, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            apply8(tbl[i], i);

        // Modulus 5: clamp on load, wrap at both ends
        step5(1, 0, 0, 0, 1, "m5 reset", 0, 0);
        step5(0, 1, 6, 0, 1, "m5 load clamp", 4, 0);
        step5(0, 0, 0, 1, 1, "m5 up wrap", 0, 1);
        step5(0, 0, 0, 1, 0, "m5 down wrap", 4, 1);
        step5(0, 0, 0, 1, 0, "m5 down", 3, 0);
        step5(0, 0, 0, 1, 1, "m5 up", 4, 0);
        chk("m5 dir", int'(dir5), 1);
        step5(0, 1, 7, 1, 1, "m5 load7 clamp", 4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
